// File: rtl/m_axi_fwft_fifo.sv
// First-word-fall-through FIFO: registered-read RAM behind a small prefetch pipeline
// (read address -> RAM dout -> head), so back-to-back pops sustain one word per cycle.
module m_axi_fwft_fifo #(
    parameter              MEM_STYLE  = "auto",
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 6,
    parameter int          DEPTH      = 63,
    parameter int          AF_THRESH  = DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  almost_full
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CW-1:0]         FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0]         AF_CNT    = CW'(AF_THRESH);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_VALID} state_t;
    state_t state;

    (* ram_style = MEM_STYLE *)
    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    logic [ADDR_WIDTH-1:0] wptr, rptr, raddr;
    logic [CW-1:0]         avail;
    logic                  rd_pend, dout_v;
    logic [DATA_WIDTH-1:0] ram_dout;

    logic          push, pop, head_v, head_free, land, dout_free, latch, pend_free, issue;
    logic          pend_nxt, dout_v_nxt;
    logic [CW-1:0] usedw_nxt, avail_nxt;

    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // Each stage advances only when the stage ahead of it is free or draining this cycle;
    // a RAM word stays counted in avail until its read is issued, so it cannot be overwritten.
    always_comb begin
        head_v     = (state == ST_VALID);
        if_empty_n = head_v;
        push       = clk_en & if_write & if_full_n;
        pop        = clk_en & if_read & head_v;
        head_free  = ~head_v | pop;
        land       = dout_v & head_free;
        dout_free  = ~dout_v | land;
        latch      = rd_pend & dout_free;
        pend_free  = ~rd_pend | latch;
        issue      = (avail != '0) & pend_free;
        pend_nxt   = issue | (rd_pend & ~latch);
        dout_v_nxt = latch | (dout_v & ~land);
        avail_nxt  = avail + CW'(push) - CW'(issue);
        usedw_nxt  = usedw + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wptr] <= if_din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            wptr        <= '0;
            rptr        <= '0;
            raddr       <= '0;
            avail       <= '0;
            rd_pend     <= 1'b0;
            dout_v      <= 1'b0;
            ram_dout    <= '0;
            if_dout     <= '0;
            usedw       <= '0;
            if_full_n   <= 1'b0;
            almost_full <= 1'b0;
        end else if (clk_en) begin
            if (push)
                wptr <= next_ptr(wptr);
            if (issue) begin
                raddr <= rptr;
                rptr  <= next_ptr(rptr);
            end
            if (latch)
                ram_dout <= mem[raddr];
            if (land)
                if_dout <= ram_dout;
            rd_pend     <= pend_nxt;
            dout_v      <= dout_v_nxt;
            avail       <= avail_nxt;
            usedw       <= usedw_nxt;
            if_full_n   <= (usedw_nxt != FULL_CNT);
            almost_full <= (usedw_nxt >= AF_CNT);
            case (state)
                ST_EMPTY: if (issue) state <= ST_FILL;
                ST_FILL:  if (land) state <= ST_VALID;
                ST_VALID: if (pop && !land)
                              state <= (pend_nxt | dout_v_nxt) ? ST_FILL : ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end
endmodule
